// File: rtl/lzc_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-cycle leading-zero counter.
// Optional feature macro: LZC_CTRL_NORM_EN (normalized operand output).
package lzc_ctrl_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   localparam int unsigned DefChunk = 4;

   // Leading-zero count of one chunk at the default chunk width.
   typedef logic [$clog2(DefChunk)-1:0] chunk_cnt_t;

   function automatic int unsigned cw_of(int unsigned w);
      return $clog2(w + 1);
   endfunction

   function automatic int unsigned nch_of(int unsigned w, int unsigned chunk);
      return w / chunk;
   endfunction

endpackage

// File: rtl/lzc_ctrl_if.sv
// Operand/result handshake bundle for lzc_ctrl.
// Optional feature macro: LZC_CTRL_NORM_EN adds out_norm.
interface lzc_ctrl_if #(
   parameter int unsigned W = 32
);
   import lzc_ctrl_pkg::*;

   localparam int unsigned CW = cw_of(W);

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_count;
   logic          out_zero;
`ifdef LZC_CTRL_NORM_EN
   logic [W-1:0]  out_norm;
`endif

   modport master (
      output in_valid, in_data, flush, out_ready,
`ifdef LZC_CTRL_NORM_EN
      input  out_norm,
`endif
      input  in_ready, out_valid, out_count, out_zero
   );

   modport slave (
      input  in_valid, in_data, flush, out_ready,
`ifdef LZC_CTRL_NORM_EN
      output out_norm,
`endif
      output in_ready, out_valid, out_count, out_zero
   );

endinterface

// File: rtl/lzc_chunk.sv
// Combinational leading-zero count of one CHUNK-bit slice, with all-zero flag.
module lzc_chunk #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0]         chunk_i,
   output logic [$clog2(CHUNK)-1:0] cnt_o,
   output logic                     zero_o
);
   import lzc_ctrl_pkg::*;

   localparam int unsigned CCW = $clog2(CHUNK);

   always_comb begin
      cnt_o  = '0;
      zero_o = 1'b1;
      // First set bit from the MSB wins.
      for (int i = 0; i < CHUNK; i++) begin
         if (zero_o && chunk_i[CHUNK-1-i]) begin
            cnt_o  = CCW'(i);
            zero_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/lzc_ctrl.sv
// Multi-cycle leading-zero counter: scans the operand MSB-first, CHUNK bits per cycle.
// Optional feature macro: LZC_CTRL_NORM_EN (registered normalized operand on out_norm).
module lzc_ctrl #(
   parameter int unsigned W     = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   lzc_ctrl_if.slave bus
);
   import lzc_ctrl_pkg::*;

   localparam int unsigned CW  = cw_of(W);
   localparam int unsigned NCH = nch_of(W, CHUNK);
   localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CCW = $clog2(CHUNK);

   state_e        state_q;
   logic [W-1:0]  shreg_q;
   logic [IW-1:0] idx_q;
   logic [CW-1:0] count_q;
   logic          zero_q;
`ifdef LZC_CTRL_NORM_EN
   logic [W-1:0]  norm_q;
`endif

   logic [CCW-1:0] chunk_cnt;
   logic           chunk_zero;

   lzc_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .chunk_i (shreg_q[W-1 -: CHUNK]),
      .cnt_o   (chunk_cnt),
      .zero_o  (chunk_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         shreg_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
         zero_q  <= 1'b0;
`ifdef LZC_CTRL_NORM_EN
         norm_q  <= '0;
`endif
      end else if (bus.flush) begin
         // Abort wins over everything, including acceptance in IDLE.
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  shreg_q <= bus.in_data;
                  count_q <= '0;
                  idx_q   <= '0;
                  state_q <= StScan;
               end
            end
            StScan: begin
               if (chunk_zero) begin
                  if (idx_q == IW'(NCH - 1)) begin
                     count_q <= CW'(W);
                     zero_q  <= 1'b1;
`ifdef LZC_CTRL_NORM_EN
                     norm_q  <= '0;
`endif
                     state_q <= StDone;
                  end else begin
                     count_q <= count_q + CW'(CHUNK);
                     shreg_q <= shreg_q << CHUNK;
                     idx_q   <= idx_q + IW'(1);
                  end
               end else begin
                  count_q <= count_q + CW'(chunk_cnt);
                  zero_q  <= 1'b0;
`ifdef LZC_CTRL_NORM_EN
                  // shreg already dropped the leading zero chunks.
                  norm_q  <= shreg_q << chunk_cnt;
`endif
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_count = count_q;
   assign bus.out_zero  = zero_q;
`ifdef LZC_CTRL_NORM_EN
   assign bus.out_norm  = norm_q;
`endif

endmodule
